// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode
// constants, opcode classes, datapath mux select constants and the bundle of
// control outputs decoded from the state register.
package ctrl_pkg;

  // FSM states; the numeric value is also exported on the debug state port.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ILLEGAL  = 4'd11,
    HALT     = 4'd12
  } state_e;

  // Opcode classes latched in DECODE.
  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_BEQ  = 3'd2,
    CLS_LW   = 3'd3,
    CLS_SW   = 3'd4,
    CLS_J    = 3'd5,
    CLS_ILL  = 3'd6,
    CLS_HALT = 3'd7
  } opclass_e;

  // Exact opcodes; R-type is 000xxx and I-type is 001xxx.
  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b011000;
  localparam logic [5:0] OP_SW   = 6'b011001;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // ALUSrcB selects.
  localparam logic [1:0] ALUB_REG = 2'd0;
  localparam logic [1:0] ALUB_ONE = 2'd1;
  localparam logic [1:0] ALUB_IMM = 2'd2;

  // PCSrc selects.
  localparam logic [1:0] PCSRC_ALU = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  // Control outputs produced for the datapath in a given state.
  typedef struct packed {
    logic       select_ins;
    logic       ir_write;
    logic       pc_write;
    logic       beq;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode from the IR toward the controller,
// control strobes/selects and debug state back toward the datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       SelectIns;
  logic       IRWrite;
  logic       PCWrite;
  logic       BEQ;
  logic [1:0] PCSrc;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       MemWrite;
  logic       MemtoReg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode,
    output SelectIns, IRWrite, PCWrite, BEQ, PCSrc, RegWrite, RegDst,
           ALUSrcA, ALUSrcB, MemWrite, MemtoReg, illegal, state
  );

  modport slave (
    output opcode,
    input  SelectIns, IRWrite, PCWrite, BEQ, PCSrc, RegWrite, RegDst,
           ALUSrcA, ALUSrcB, MemWrite, MemtoReg, illegal, state
  );
endinterface

// File: rtl/opcode_class_decode.sv
// Combinational opcode -> opcode class decoder.
// Ports: opcode_i (6-bit IR opcode), class_o (opclass_e).
// Build option MULTICYCLE_CTRL_HALT_EN: 111111 decodes to HALT instead of illegal.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output opclass_e   class_o
);

  always_comb begin
    class_o = CLS_ILL;
    casez (opcode_i)
      6'b000???: class_o = CLS_R;
      6'b001???: class_o = CLS_I;
      OP_BEQ:    class_o = CLS_BEQ;
      OP_LW:     class_o = CLS_LW;
      OP_SW:     class_o = CLS_SW;
      OP_J:      class_o = CLS_J;
`ifdef MULTICYCLE_CTRL_HALT_EN
      OP_HALT:   class_o = CLS_HALT;
`endif
      default:   class_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM controller for a multicycle datapath.
// Ports: clk, reset (sync, active-high), bus (multicycle_control_if.master:
//   opcode in; control strobes/selects, illegal pulse and debug state out).
// Build option MULTICYCLE_CTRL_HALT_EN enables the HALT state for opcode 111111.
module multicycle_control
  import ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  state_e   state_q, state_d;
  opclass_e class_q, class_d;
  opclass_e dec_class;
  // Set by reset; keeps the FSM parked in FETCH with all outputs quiet until
  // the first edge that samples reset low, so a reset never leaves a write.
  logic     hold_q;
  ctrl_t    ctrl;

  opcode_class_decode u_dec (
    .opcode_i (bus.opcode),
    .class_o  (dec_class)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      class_q <= CLS_R;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      hold_q  <= 1'b0;
    end
  end

  // Next state. The opcode port is only looked at in DECODE; later states
  // steer on the latched class.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    if (!hold_q) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          class_d = dec_class;
          case (dec_class)
            CLS_R:    state_d = EXEC_R;
            CLS_I:    state_d = EXEC_I;
            CLS_LW,
            CLS_SW:   state_d = MEM_ADDR;
            CLS_BEQ:  state_d = BRANCH;
            CLS_J:    state_d = JUMP;
            CLS_HALT: state_d = HALT;
            default:  state_d = ILLEGAL;
          endcase
        end
        EXEC_R,
        EXEC_I:   state_d = ALU_WB;
        MEM_ADDR: state_d = (class_q == CLS_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   state_d = MEM_WB;
        HALT:     state_d = HALT;
        default:  state_d = FETCH;
      endcase
    end
  end

  // Moore outputs from state_q/class_q only.
  always_comb begin
    ctrl = '0;
    if (!hold_q) begin
      case (state_q)
        FETCH: begin
          ctrl.select_ins = 1'b1;
          ctrl.ir_write   = 1'b1;
          ctrl.pc_write   = 1'b1;
          ctrl.alu_src_a  = 1'b0;
          ctrl.alu_src_b  = ALUB_ONE;
          ctrl.pc_src     = PCSRC_ALU;
        end
        EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_REG;
        end
        EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_IMM;
        end
        ALU_WB: begin
          // Keep the ALU operands of the execute step stable during write-back.
          ctrl.reg_write = 1'b1;
          ctrl.alu_src_a = 1'b1;
          if (class_q == CLS_I) begin
            ctrl.reg_dst   = 1'b0;
            ctrl.alu_src_b = ALUB_IMM;
          end else begin
            ctrl.reg_dst   = 1'b1;
            ctrl.alu_src_b = ALUB_REG;
          end
        end
        MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_IMM;
        end
        // MEM_RD: the address sits in the ALU output register; nothing driven.
        MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_dst    = 1'b0;
        end
        MEM_WR:  ctrl.mem_write = 1'b1;
        BRANCH: begin
          ctrl.beq       = 1'b1;
          ctrl.pc_src    = PCSRC_BR;
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_REG;
        end
        JUMP: begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_JMP;
        end
        ILLEGAL: ctrl.illegal = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.SelectIns = ctrl.select_ins;
  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.PCWrite   = ctrl.pc_write;
  assign bus.BEQ       = ctrl.beq;
  assign bus.PCSrc     = ctrl.pc_src;
  assign bus.RegWrite  = ctrl.reg_write;
  assign bus.RegDst    = ctrl.reg_dst;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.MemWrite  = ctrl.mem_write;
  assign bus.MemtoReg  = ctrl.mem_to_reg;
  assign bus.illegal   = ctrl.illegal;
  assign bus.state     = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port opcode, input, 6, instruction opcode from the datapath IR; sampled only in DECODE.
REQ-004 SHALL drive the datapath control outputs, each 1 bit unless stated:
- SelectIns: 1 = memory port addressed by PC (fetch).
- IRWrite: load IR.
- PCWrite: unconditional PC load.
- BEQ: conditional PC load when ALU zero.
- PCSrc (2): 0 = ALU result, 1 = branch target, 2 = jump target.
- RegWrite: register-file write.
- RegDst: 1 = rd, 0 = rt.
- ALUSrcA: 1 = register A, 0 = PC.
- ALUSrcB (2): 0 = register B, 1 = constant 1, 2 = sign-extended immediate.
- MemWrite: data-memory write.
- MemtoReg: 1 = write-back from memory data.
REQ-005 SHALL drive output illegal (1): one-cycle pulse on an unrecognised opcode.
REQ-006 SHALL drive output state (4): current state encoding, for debug.

Function
REQ-007 SHALL implement a Moore FSM; every control output is decoded from the state register and the latched opcode class only, never directly from the opcode port.
REQ-008 SHALL use states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, ILLEGAL (plus HALT per REQ-021).
REQ-009 SHALL decode opcode classes as follows:
- 000xxx R-type.
- 001xxx I-type ALU.
- 010000 BEQ.
- 011000 LW.
- 011001 SW.
- 100000 J.
- All others illegal.
REQ-010 FETCH SHALL assert SelectIns=1, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, PCSrc=0, and SHALL go to DECODE.
REQ-011 DECODE SHALL latch the opcode class into a register and branch by class to EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JUMP or ILLEGAL.
REQ-012 The R-type path SHALL be as follows:
- EXEC_R: ALUSrcA=1, ALUSrcB=0.
- ALU_WB: RegWrite=1, RegDst=1, MemtoReg=0, ALUSrcA=1, ALUSrcB=0.
REQ-013 The I-type path SHALL be as follows:
- EXEC_I: ALUSrcA=1, ALUSrcB=2.
- ALU_WB: RegWrite=1, RegDst=0, ALUSrcA=1, ALUSrcB=2.
REQ-014 The memory path SHALL be as follows:
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2; goes to MEM_RD for LW or MEM_WR for SW.
- MEM_RD holds the address.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEM_WR: MemWrite=1 for exactly one cycle.
REQ-015 BRANCH SHALL assert BEQ=1, PCSrc=1, ALUSrcA=1, ALUSrcB=0; JUMP SHALL assert PCWrite=1, PCSrc=2.
REQ-016 ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP and ILLEGAL SHALL return to FETCH.
REQ-017 Instruction latency, FETCH to FETCH, SHALL be: R/I 4 cycles, LW 5, SW 4, BEQ 3, J 3, illegal 3.
REQ-018 Every output not named for a state SHALL be 0 in that state; RegWrite, MemWrite, PCWrite and BEQ SHALL never be asserted in the same cycle as one another, except PCWrite with IRWrite in FETCH.
REQ-019 ILLEGAL SHALL pulse illegal=1 for one cycle with no register, memory or PC write.

Reset
REQ-020 SHALL enter FETCH on the edge where reset=1, clear the latched class to R-type and hold illegal=0; reset mid-instruction (including during MEM_WR) SHALL abort with no write on the following cycle; the first FETCH outputs appear in the cycle after reset deasserts.

Configuration
REQ-021 With MULTICYCLE_CTRL_HALT_EN defined:
- Opcode 111111 SHALL decode to HALT, with all outputs 0, remaining in HALT until reset.
- Without the macro, 111111 SHALL be treated as illegal.

Structure
REQ-022 A shared package ctrl_pkg SHALL hold the state enumeration, the opcode constants, the opcode-class enumeration and the ALUSrcB/PCSrc select constants.
REQ-023 One combinational sub-module SHALL be used: opcode_class_decode (opcode in, class out); the FSM and output decode SHALL stay in multicycle_control.

Verification
REQ-024 Reset asserted 2 cycles, then opcode=000000: states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; RegWrite=1 and RegDst=1 only in cycle 4.
REQ-025 opcode=011000 (LW): 5-cycle sequence; MemtoReg=1 and RegWrite=1 in MEM_WB only; MemWrite stays 0 throughout.
REQ-026 opcode=011001 (SW): MemWrite=1 for exactly 1 cycle (cycle 4); reset applied in MEM_ADDR gives MemWrite=0 and state FETCH on the next cycle.
REQ-027 opcode=010000 then 100000: BRANCH drives BEQ=1, PCSrc=1; JUMP drives PCWrite=1, PCSrc=2; each instruction takes 3 cycles.
REQ-028 opcode=101010: illegal=1 for one cycle in cycle 3, no writes, then FETCH.
REQ-029 opcode=111111: with the macro, FSM stays in HALT for 20 cycles until reset; without it, the illegal pulse of REQ-028 occurs.
